i2c_apb_sequencer: RTL
======================

I2C_APB_SEQUENCER -- requirements
Module: i2c_apb_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, APB data width.
REQ-003 The block SHALL have parameter DONE_BIT, default 4, status bit index meaning transfer complete.
REQ-004 The block SHALL have parameter POLL_LIMIT, default 255, maximum status reads before timeout.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: pclk_i (in, 1, clock) and preset_ni (in, 1, reset, active low).
REQ-006 The block SHALL have the job ports: job_valid_i in 1; job_ready_o out 1; job_rw_i in 1 (1 = read); job_len_i in 4 (byte count, 0 = no data phase); job_saddr_i in 8; job_prescale_i in 8; job_cmd_i in 8 (command register value).
REQ-007 The block SHALL have the TX stream ports: tx_valid_i in 1; tx_data_i in 8; tx_ready_o out 1.
REQ-008 The block SHALL have the RX stream ports: rx_valid_o out 1; rx_data_o out 8; rx_ready_i in 1.
REQ-009 The block SHALL have the APB master ports: paddr_o out ADDR_WIDTH; pwrite_o out 1; psel_o out 1; penable_o out 1; pwdata_o out DATA_WIDTH; prdata_i in DATA_WIDTH; pready_i in 1.
REQ-010 The block SHALL have the completion ports: done_o out 1 (one-cycle pulse); error_o out 1 (one-cycle pulse, with done_o, on timeout).

Function
REQ-011 Register map SHALL be: 0x00 transmit, 0x01 RX data, 0x02 status, 0x03 slave address, 0x04 command, 0x05 prescale.
REQ-012 Every APB transfer SHALL take a SETUP cycle (psel_o=1, penable_o=0) and then ACCESS cycles (psel_o=1, penable_o=1) until pready_i=1; paddr_o, pwrite_o and pwdata_o SHALL stay stable from SETUP to completion.
REQ-013 psel_o and penable_o SHALL be 0 in every cycle between transfers; transfers SHALL never be issued back-to-back without an idle cycle.
REQ-014 The FSM states SHALL be IDLE, PRESCALE, SADDR, TXDATA, CMD, POLL, RXDATA, RXOUT, DONE.
REQ-015 IDLE SHALL assert job_ready_o; on job_valid_i and job_ready_o it SHALL latch all job fields and go to PRESCALE.
REQ-016 PRESCALE SHALL write job_prescale to 0x05, then go to SADDR.
REQ-017 SADDR SHALL write {job_saddr[6:0], job_rw} to 0x03, then go to TXDATA if rw=0 and len!=0, else to CMD.
REQ-018 TXDATA SHALL assert tx_ready_o only in IDLE-gap cycles with no transfer pending; on tx_valid_i and tx_ready_o it SHALL write tx_data_i to 0x00; after len writes it SHALL go to CMD; with no tx_valid_i it SHALL wait indefinitely.
REQ-019 CMD SHALL write job_cmd to 0x04, clear the poll counter, and go to POLL.
REQ-020 POLL SHALL read 0x02, sampling prdata_i in the completing ACCESS cycle; if bit DONE_BIT=1 it SHALL go to RXDATA when rw=1 and len!=0, else to DONE; otherwise it SHALL increment the counter and repeat.
REQ-021 On the POLL_LIMIT-th read with DONE_BIT=0, the FSM SHALL go to DONE with the error flag set.
REQ-022 RXDATA SHALL read 0x01 and latch the sampled byte into rx_data_o, then go to RXOUT.
REQ-023 RXOUT SHALL hold rx_valid_o=1 until rx_ready_i=1; after the handshake it SHALL return to RXDATA until len bytes are delivered, then go to DONE.
REQ-024 DONE SHALL pulse done_o (and error_o if flagged) for exactly one cycle, then return to IDLE.
REQ-025 The byte counter SHALL be 4 bits and count from 0 to len-1, with no wrap; len=0 SHALL skip TXDATA and RXDATA entirely.
REQ-026 job_valid_i SHALL be ignored outside IDLE; job field changes after acceptance SHALL have no effect.
REQ-027 The poll counter SHALL saturate at POLL_LIMIT and SHALL NOT wrap.

Reset
REQ-028 When preset_ni=0, the block SHALL reset asynchronously to IDLE and drive all outputs to 0 (paddr_o, pwdata_o, rx_data_o included), except job_ready_o, which SHALL be 1 once in IDLE.
REQ-029 Reset mid-transfer SHALL drop psel_o and penable_o immediately; the aborted job SHALL NOT produce done_o.

Verification
REQ-030 Write job: len=2, prescale=0x10, saddr=0x50, cmd=0xC0, bytes 0xA5, 0x3C, status returns 0x10 on the first poll -> APB writes 05:10, 03:A0, 00:A5, 00:3C, 04:C0, then read 02, then one done_o pulse, error_o=0.
REQ-031 Read job: len=3, status done on the third poll, RX bytes 0x11, 0x22, 0x33, rx_ready_i held low 2 cycles per byte -> 03:A1, exactly 3 status reads, rx_data_o=0x11, 0x22, 0x33 each held until rx_ready_i, then done_o.
REQ-032 pready_i low 3 cycles on the CMD write -> penable_o high 4 cycles with paddr_o and pwdata_o stable; the sequence otherwise identical.
REQ-033 Status never sets DONE_BIT, POLL_LIMIT=4 -> exactly 4 status reads, then done_o=1 and error_o=1 in the same cycle, then back to IDLE.
REQ-034 preset_ni asserted during the ACCESS cycle of the second TX write -> psel_o=0 asynchronously, no done_o, job_ready_o=1 after release; a new job runs cleanly from PRESCALE.
REQ-035 len=0 write job -> no 0x00 writes and no tx_ready_o assertion; the sequence is 05, 03, 04, polls, done.

Source files
------------

// File: rtl/i2c_apb_sequencer_if.sv
// rtl/i2c_apb_sequencer_if.sv - APB bus bundle between the sequencer and the I2C controller registers
interface i2c_apb_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic                  pwrite_o;
    logic                  psel_o;
    logic                  penable_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;

    modport master (
        output paddr_o, pwrite_o, psel_o, penable_o, pwdata_o,
        input  prdata_i, pready_i
    );

    modport slave (
        input  paddr_o, pwrite_o, psel_o, penable_o, pwdata_o,
        output prdata_i, pready_i
    );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// rtl/i2c_apb_sequencer.sv - runs one I2C job as a fixed sequence of APB register accesses
module i2c_apb_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DONE_BIT   = 4,
    parameter int POLL_LIMIT = 255
) (
    input  logic       pclk_i,
    input  logic       preset_ni,
    input  logic       job_valid_i,
    output logic       job_ready_o,
    input  logic       job_rw_i,
    input  logic [3:0] job_len_i,
    input  logic [7:0] job_saddr_i,
    input  logic [7:0] job_prescale_i,
    input  logic [7:0] job_cmd_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_ready_i,
    i2c_apb_sequencer_if.master apb,
    output logic       done_o,
    output logic       error_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRESCALE, S_SADDR, S_TXDATA, S_CMD, S_POLL, S_RXDATA, S_RXOUT, S_DONE
    } state_t;

    // GAP is the mandatory idle cycle in front of every transfer
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic            rw_q;
    logic [3:0]      len_q;
    logic [6:0]      saddr_q;
    logic [7:0]      prescale_q;
    logic [7:0]      cmd_q;
    logic [7:0]      tx_byte_q;
    logic [3:0]      byte_cnt_q;
    logic [PW-1:0]   poll_cnt_q;
    logic            err_q;
    logic [7:0]      rx_data_q;

    logic            in_xfer;
    logic            xfer_done;
    logic            byte_last;
    logic            status_done;
    logic [ADDR_WIDTH-1:0] xfer_addr;
    logic            xfer_wr;
    logic [DATA_WIDTH-1:0] xfer_wdata;

    assign byte_last   = (byte_cnt_q == len_q - 4'd1);
    assign status_done = apb.prdata_i[DONE_BIT];
    assign rx_data_o   = rx_data_q;

    // state and bus phase registers
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q <= S_IDLE;
            phase_q <= PH_GAP;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // next state, bus phase sequencing and all outputs
    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        job_ready_o      = 1'b0;
        tx_ready_o       = 1'b0;
        rx_valid_o       = 1'b0;
        done_o           = 1'b0;
        error_o          = 1'b0;
        apb.psel_o       = 1'b0;
        apb.penable_o    = 1'b0;
        apb.pwrite_o     = 1'b0;
        apb.paddr_o      = '0;
        apb.pwdata_o     = '0;
        in_xfer          = 1'b1;
        xfer_done        = 1'b0;
        xfer_wr          = 1'b1;
        xfer_addr        = '0;
        xfer_wdata       = '0;

        case (state_q)
            S_PRESCALE: begin xfer_addr = ADDR_WIDTH'(5); xfer_wdata = DATA_WIDTH'(prescale_q); end
            S_SADDR:    begin xfer_addr = ADDR_WIDTH'(3); xfer_wdata = DATA_WIDTH'({saddr_q, rw_q}); end
            S_TXDATA:   begin xfer_addr = ADDR_WIDTH'(0); xfer_wdata = DATA_WIDTH'(tx_byte_q); end
            S_CMD:      begin xfer_addr = ADDR_WIDTH'(4); xfer_wdata = DATA_WIDTH'(cmd_q); end
            S_POLL:     begin xfer_addr = ADDR_WIDTH'(2); xfer_wr = 1'b0; end
            S_RXDATA:   begin xfer_addr = ADDR_WIDTH'(1); xfer_wr = 1'b0; end
            default:    begin in_xfer = 1'b0; xfer_wr = 1'b0; end
        endcase

        if (in_xfer) begin
            case (phase_q)
                PH_GAP: begin
                    // a TX write only starts once the stream hands over a byte
                    tx_ready_o = (state_q == S_TXDATA);
                    if (state_q != S_TXDATA || tx_valid_i) phase_d = PH_SETUP;
                end
                PH_SETUP: begin
                    phase_d = PH_ACCESS;
                end
                default: begin
                    if (apb.pready_i) begin
                        xfer_done = 1'b1;
                        phase_d   = PH_GAP;
                    end
                end
            endcase
            if (phase_q != PH_GAP) begin
                apb.psel_o    = 1'b1;
                apb.penable_o = (phase_q == PH_ACCESS);
                apb.paddr_o   = xfer_addr;
                apb.pwrite_o  = xfer_wr;
                apb.pwdata_o  = xfer_wr ? xfer_wdata : '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                job_ready_o = 1'b1;
                if (job_valid_i) state_d = S_PRESCALE;
            end
            S_PRESCALE: if (xfer_done) state_d = S_SADDR;
            S_SADDR: if (xfer_done) state_d = (!rw_q && len_q != 4'd0) ? S_TXDATA : S_CMD;
            S_TXDATA: if (xfer_done && byte_last) state_d = S_CMD;
            S_CMD: if (xfer_done) state_d = S_POLL;
            S_POLL: begin
                if (xfer_done) begin
                    if (status_done) state_d = (rw_q && len_q != 4'd0) ? S_RXDATA : S_DONE;
                    else if (poll_cnt_q == POLL_LAST) state_d = S_DONE;
                end
            end
            S_RXDATA: if (xfer_done) state_d = S_RXOUT;
            S_RXOUT: begin
                rx_valid_o = 1'b1;
                if (rx_ready_i) state_d = byte_last ? S_DONE : S_RXDATA;
            end
            S_DONE: begin
                done_o  = 1'b1;
                error_o = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // job latch, byte/poll counters, error flag and received byte
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            rw_q       <= 1'b0;
            len_q      <= 4'd0;
            saddr_q    <= 7'd0;
            prescale_q <= 8'd0;
            cmd_q      <= 8'd0;
            tx_byte_q  <= 8'd0;
            byte_cnt_q <= 4'd0;
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
            rx_data_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (job_valid_i) begin
                        rw_q       <= job_rw_i;
                        len_q      <= job_len_i;
                        saddr_q    <= job_saddr_i[6:0];
                        prescale_q <= job_prescale_i;
                        cmd_q      <= job_cmd_i;
                        byte_cnt_q <= 4'd0;
                        poll_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                S_TXDATA: begin
                    if (tx_ready_o && tx_valid_i) tx_byte_q <= tx_data_i;
                    if (xfer_done && !byte_last) byte_cnt_q <= byte_cnt_q + 4'd1;
                end
                S_CMD: begin
                    if (xfer_done) begin
                        byte_cnt_q <= 4'd0;
                        poll_cnt_q <= '0;
                    end
                end
                S_POLL: begin
                    if (xfer_done && !status_done) begin
                        if (poll_cnt_q < POLL_MAX) poll_cnt_q <= poll_cnt_q + 1'b1;
                        if (poll_cnt_q == POLL_LAST) err_q <= 1'b1;
                    end
                end
                S_RXDATA: begin
                    if (xfer_done) rx_data_q <= apb.prdata_i[7:0];
                end
                S_RXOUT: begin
                    if (rx_ready_i && !byte_last) byte_cnt_q <= byte_cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
